cordic_freq_est: RTL



---
 rtl/cordic_pkg.sv | 9 +
 rtl/cordic_freq_est.sv | 84 ++++++++
 2 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: widths, sample types and frequency-estimator states shared by cordic and its consumers
package cordic_pkg;
  localparam int AMP_W = 12;
  localparam int PHI_W = 11;
  typedef logic [AMP_W-1:0] amp_t;
  typedef logic [PHI_W-1:0] phi_t;
  typedef logic signed [PHI_W-1:0] freq_t;
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} freq_est_state_t;
endpackage

// File: rtl/cordic_freq_est.sv
// cordic_freq_est: block-averaged wrapped phase step of qualifying polar samples
module cordic_freq_est
  import cordic_pkg::*;
#(
  parameter int LOG2_N = 2,
  parameter int AMP_THRESH = 64
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  amp_t  amp_i,
  input  phi_t  phi_i,
  input  logic  valid_i,
  output logic  ready_o,
  output freq_t freq_o,
  output logic  valid_o,
  input  logic  ready_i
);
  localparam int ACC_W = PHI_W + LOG2_N;
  localparam amp_t THRESH = amp_t'(AMP_THRESH);
  freq_est_state_t state;
  logic signed [ACC_W-1:0] acc, sum;
  logic [LOG2_N-1:0] cnt;
  phi_t prev;
  freq_t d, mean;
  logic take, qual;
  // modulo-2^11 subtraction reinterpreted as signed gives the wrapped step directly
  always_comb begin
    take = valid_i && ready_o;
    qual = amp_i >= THRESH;
    d = freq_t'(phi_i - prev);
    sum = acc + ACC_W'(d);
    mean = freq_t'(sum >>> LOG2_N);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      prev <= '0;
      freq_o <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready_o <= 1'b1;
          if (take && qual) begin
            prev <= phi_i;
            acc <= '0;
            cnt <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: if (take) begin
          if (!qual) begin
            acc <= '0;
            cnt <= '0;
            prev <= '0;
            state <= IDLE;
          end else begin
            prev <= phi_i;
            acc <= sum;
            cnt <= cnt + LOG2_N'(1);
            if (cnt == '1) begin
              freq_o <= mean;
              valid_o <= 1'b1;
              ready_o <= 1'b0;
              state <= OUTPUT;
            end
          end
        end
        OUTPUT: if (ready_i) begin
          // last sample of this block stays as the reference for the next
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          acc <= '0;
          cnt <= '0;
          state <= ACCUM;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
